// File: rtl/ro_puf_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ro_puf_sequencer_pkg
// Brief   : Shared types, widths and default parameters for the RO-PUF sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package ro_puf_sequencer_pkg;

    localparam int CTR_W           = 8;
    localparam int N_BITS_DEF      = 8;
    localparam int SETTLE_CYC_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 4095;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Bit width needed to index n items; never below one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ro_puf_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ro_puf_sequencer_if
// Brief   : Request / response handshake between a consumer and the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface ro_puf_sequencer_if
    import ro_puf_sequencer_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) ();

    logic              req;
    logic              busy;
    logic [N_BITS-1:0] resp;
    logic              resp_valid;
    logic              resp_ready;
    logic              tie;
    logic              timeout_err;

    // master = consumer issuing requests, slave = sequencer serving them
    modport master (
        output req, resp_ready,
        input  busy, resp, resp_valid, tie, timeout_err
    );

    modport slave (
        input  req, resp_ready,
        output busy, resp, resp_valid, tie, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/ro_puf_timeout.sv
`default_nettype none
// ============================================================================
// Module  : ro_puf_timeout
// Brief   : Loadable RUN-cycle counter with clear, enable and expiry flag.
// Revision: 1.0 - initial release
// ============================================================================
module ro_puf_timeout
    import ro_puf_sequencer_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYC_DEF,
    parameter int WIDTH = width_of(LIMIT + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_en,
    output logic                  o_expired
);

    logic [WIDTH-1:0] r_count;

    // Expiry flags the enabled cycle whose increment brings the count to LIMIT.
    assign o_expired = i_en && (r_count >= WIDTH'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != WIDTH'(LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ro_puf_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ro_puf_sequencer
// Brief   : Steps through ring-oscillator pairs, compares counts, builds response.
// Revision: 1.0 - initial release
// ============================================================================
module ro_puf_sequencer
    import ro_puf_sequencer_pkg::*;
#(
    parameter int N_BITS      = N_BITS_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    ro_puf_sequencer_if.slave             if_rsp,
    output logic [width_of(N_BITS)-1:0]   o_ro_sel,
    output logic                          o_ro_en,
    output logic                          o_ctr_start,
    input  wire logic                     i_ctr_done,
    input  wire logic [CTR_W-1:0]         i_ctr_count1,
    input  wire logic [CTR_W-1:0]         i_ctr_count2
);

    localparam int IDX_W = width_of(N_BITS);
    localparam int SET_W = width_of(SETTLE_CYC);
    localparam int TMR_W = width_of(TIMEOUT_CYC + 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [SET_W-1:0]  r_settle;
    logic [N_BITS-1:0] r_resp;
    logic              r_tie;
    logic              r_to;
    logic              r_timed_out;
    logic              r_ro_en;
    logic              r_ctr_start;
    logic              r_busy;
    logic              r_valid;

    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_tmr_expired;

    // Counter is held at zero throughout SETTLE so every RUN starts from zero.
    assign w_tmr_clr = (r_state == ST_SETTLE);
    assign w_tmr_en  = (r_state == ST_RUN);

    ro_puf_timeout #(
        .LIMIT (TIMEOUT_CYC),
        .WIDTH (TMR_W)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_tmr_clr),
        .i_load     (1'b0),
        .i_load_val ({TMR_W{1'b0}}),
        .i_en       (w_tmr_en),
        .o_expired  (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_settle    <= '0;
            r_resp      <= '0;
            r_tie       <= 1'b0;
            r_to        <= 1'b0;
            r_timed_out <= 1'b0;
            r_ro_en     <= 1'b0;
            r_ctr_start <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (if_rsp.req) begin
                        r_state  <= ST_SETTLE;
                        r_idx    <= '0;
                        r_settle <= '0;
                        r_resp   <= '0;
                        r_tie    <= 1'b0;
                        r_to     <= 1'b0;
                        r_ro_en  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == SET_W'(SETTLE_CYC - 1)) begin
                        r_state     <= ST_RUN;
                        r_settle    <= '0;
                        r_ctr_start <= 1'b1;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                ST_RUN: begin
                    // A done flag wins over a coincident timeout.
                    if (i_ctr_done || w_tmr_expired) begin
                        r_state     <= ST_CAPTURE;
                        r_ro_en     <= 1'b0;
                        r_timed_out <= !i_ctr_done;
                    end
                end
                ST_CAPTURE: begin
                    r_state     <= ST_NEXT;
                    r_ctr_start <= 1'b0;
                    if (r_timed_out) begin
                        r_resp[r_idx] <= 1'b0;
                        r_to          <= 1'b1;
                    end else begin
                        r_resp[r_idx] <= (i_ctr_count1 > i_ctr_count2);
                        if (i_ctr_count1 == i_ctr_count2) begin
                            r_tie <= 1'b1;
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_idx == IDX_W'(N_BITS - 1)) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= ST_SETTLE;
                        r_idx   <= r_idx + 1'b1;
                        r_ro_en <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (if_rsp.resp_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ro_sel           = r_idx;
    assign o_ro_en            = r_ro_en;
    assign o_ctr_start        = r_ctr_start;
    assign if_rsp.busy        = r_busy;
    assign if_rsp.resp        = r_resp;
    assign if_rsp.resp_valid  = r_valid;
    assign if_rsp.tie         = r_tie;
    assign if_rsp.timeout_err = r_to;

endmodule
`default_nettype wire
